// File: rtl/bbp_rx_deframer_if.sv
`default_nettype none
// ============================================================================
// Interface : bbp_rx_deframer_if
// Purpose   : Bundles the two streams of the receive deframer: the
//             demodulated byte stream coming in and the packed 64-bit C2H
//             stream going out.
// Modports  : slave  - deframer view (consumes bytes, produces C2H words)
//             master - environment view (demod byte source + C2H sink)
// Signals   : s_axis_demod_tvalid/tdata/tready   byte stream
//             m_axis_c2h_tdata/tkeep/tvalid/tlast/tuser/tready  word stream
// Revision  : 1.0 - initial release
// ============================================================================
interface bbp_rx_deframer_if #(
  parameter int DATA_W = 64
);
  localparam int KEEP_W = DATA_W / 8;

  logic              s_axis_demod_tvalid;
  logic [7:0]        s_axis_demod_tdata;
  logic              s_axis_demod_tready;

  logic [DATA_W-1:0] m_axis_c2h_tdata;
  logic [KEEP_W-1:0] m_axis_c2h_tkeep;
  logic              m_axis_c2h_tvalid;
  logic              m_axis_c2h_tlast;
  logic              m_axis_c2h_tuser;
  logic              m_axis_c2h_tready;

  modport slave (
    input  s_axis_demod_tvalid,
    input  s_axis_demod_tdata,
    output s_axis_demod_tready,
    output m_axis_c2h_tdata,
    output m_axis_c2h_tkeep,
    output m_axis_c2h_tvalid,
    output m_axis_c2h_tlast,
    output m_axis_c2h_tuser,
    input  m_axis_c2h_tready
  );

  modport master (
    output s_axis_demod_tvalid,
    output s_axis_demod_tdata,
    input  s_axis_demod_tready,
    input  m_axis_c2h_tdata,
    input  m_axis_c2h_tkeep,
    input  m_axis_c2h_tvalid,
    input  m_axis_c2h_tlast,
    input  m_axis_c2h_tuser,
    output m_axis_c2h_tready
  );
endinterface
`default_nettype wire

// File: rtl/bbp_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : bbp_rx_deframer
// Purpose  : Hunts for a 32-bit sync word in a demodulated byte stream,
//            reads a 16-bit big-endian length, and packs the payload
//            little-endian into 64-bit C2H words with tkeep/tlast.
// Ports    : clk_250m   - single clock, rising edge
//            reset      - asynchronous, active-high
//            bus        - bbp_rx_deframer_if.slave (byte in / word out)
//            locked     - high whenever not hunting for sync
//            frame_cnt  - delivered frames (saturating)
//            err_cnt    - bad lengths / CRC errors (saturating)
// Options  : `define BBP_RX_CRC_EN adds a trailing big-endian CRC-16-CCITT
//            (poly 0x1021, init 0xFFFF) over length + payload; the tlast
//            word is held back until the CRC is checked and tuser flags a
//            CRC error. Without it tuser is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module bbp_rx_deframer #(
  parameter int          AXIS_TDATA_WIDTH = 64,  // only 64 is supported
  parameter logic [31:0] SYNC_WORD        = 32'hEB90146F,
  parameter logic [15:0] MAX_LEN          = 16'd1500
) (
  input  wire logic        clk_250m,
  input  wire logic        reset,
  bbp_rx_deframer_if.slave bus,
  output logic             locked,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      err_cnt
);

  localparam int KEEP_W = AXIS_TDATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_PAYLOAD = 3'd3
`ifdef BBP_RX_CRC_EN
    ,ST_CRC    = 3'd4
`endif
  } state_t;

  state_t                      state_q;
  logic [31:0]                 shift_q;
  logic [15:0]                 len_q;
  logic [15:0]                 cnt_q;     // payload bytes accepted so far
  logic [AXIS_TDATA_WIDTH-1:0] pack_q;
  logic [2:0]                  idx_q;     // next byte lane in pack_q
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic [KEEP_W-1:0]           tkeep_q;
  logic                        tlast_q;
  logic                        tvalid_q;
  logic [15:0]                 frame_cnt_q;
  logic [15:0]                 err_cnt_q;

  logic                        in_ready;
  logic                        accept;
  logic                        out_hs;
  logic [7:0]                  in_byte;
  logic [31:0]                 shift_d;
  logic [15:0]                 len_d;
  logic [AXIS_TDATA_WIDTH-1:0] pack_d;
  logic                        last_byte;
  logic                        word_done;
  logic [KEEP_W-1:0]           keep_last;

  // Input is only blocked while a word is parked in the output register
  // and not being taken; a load in the same cycle as a handshake simply
  // replaces the departing word.
  assign in_ready  = !(tvalid_q && !bus.m_axis_c2h_tready);
  assign accept    = bus.s_axis_demod_tvalid && in_ready;
  assign out_hs    = tvalid_q && bus.m_axis_c2h_tready;
  assign in_byte   = bus.s_axis_demod_tdata;

  assign shift_d   = {shift_q[23:0], in_byte};
  assign len_d     = {len_q[15:8], in_byte};
  assign pack_d    = pack_q | ({{(AXIS_TDATA_WIDTH-8){1'b0}}, in_byte} << {idx_q, 3'b000});
  assign last_byte = ((cnt_q + 16'd1) == len_q);
  assign word_done = (idx_q == 3'd7) || last_byte;
  // A length that is a multiple of 8 ends on a full word.
  assign keep_last = (len_q[2:0] == 3'd0) ? {KEEP_W{1'b1}}
                                          : ((KEEP_W'(1) << len_q[2:0]) - KEEP_W'(1));

`ifdef BBP_RX_CRC_EN
  logic [15:0] crc_q;
  logic [7:0]  crc_hi_q;
  logic        crc_idx_q;
  logic        tuser_q;
  logic [15:0] crc_d;
  logic        crc_bad;

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  assign crc_d   = crc16_upd(crc_q, in_byte);
  assign crc_bad = ({crc_hi_q, in_byte} != crc_q);
  assign bus.m_axis_c2h_tuser = tuser_q;
`else
  assign bus.m_axis_c2h_tuser = 1'b0;
`endif

  always_ff @(posedge clk_250m or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      shift_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      pack_q      <= '0;
      idx_q       <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
`ifdef BBP_RX_CRC_EN
      crc_q       <= 16'hFFFF;
      crc_hi_q    <= '0;
      crc_idx_q   <= 1'b0;
      tuser_q     <= 1'b0;
`endif
    end else begin
      if (out_hs) begin
        tvalid_q <= 1'b0;
        if (tlast_q && (frame_cnt_q != 16'hFFFF)) begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
      end

      if (accept) begin
        case (state_q)
          ST_HUNT: begin
            if (shift_d == SYNC_WORD) begin
              state_q <= ST_LEN_HI;
              shift_q <= '0;
`ifdef BBP_RX_CRC_EN
              crc_q   <= 16'hFFFF;
`endif
            end else begin
              shift_q <= shift_d;
            end
          end

          ST_LEN_HI: begin
            len_q   <= {in_byte, 8'h00};
            state_q <= ST_LEN_LO;
`ifdef BBP_RX_CRC_EN
            crc_q   <= crc_d;
`endif
          end

          ST_LEN_LO: begin
            if ((len_d == 16'd0) || (len_d > MAX_LEN)) begin
              if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
              end
              state_q <= ST_HUNT;
              shift_q <= '0;
            end else begin
              len_q   <= len_d;
              cnt_q   <= '0;
              idx_q   <= '0;
              pack_q  <= '0;
              state_q <= ST_PAYLOAD;
            end
`ifdef BBP_RX_CRC_EN
            crc_q <= crc_d;
`endif
          end

          ST_PAYLOAD: begin
            cnt_q <= cnt_q + 16'd1;
`ifdef BBP_RX_CRC_EN
            crc_q <= crc_d;
`endif
            if (word_done) begin
              pack_q <= '0;
              idx_q  <= '0;
`ifdef BBP_RX_CRC_EN
              if (last_byte) begin
                // Park the final word until the CRC verdict is known.
                pack_q    <= pack_d;
                crc_idx_q <= 1'b0;
                state_q   <= ST_CRC;
              end else begin
                tdata_q  <= pack_d;
                tkeep_q  <= {KEEP_W{1'b1}};
                tlast_q  <= 1'b0;
                tuser_q  <= 1'b0;
                tvalid_q <= 1'b1;
              end
`else
              tdata_q  <= pack_d;
              tkeep_q  <= last_byte ? keep_last : {KEEP_W{1'b1}};
              tlast_q  <= last_byte;
              tvalid_q <= 1'b1;
              if (last_byte) begin
                state_q <= ST_HUNT;
              end
`endif
            end else begin
              pack_q <= pack_d;
              idx_q  <= idx_q + 3'd1;
            end
          end

`ifdef BBP_RX_CRC_EN
          ST_CRC: begin
            if (!crc_idx_q) begin
              crc_hi_q  <= in_byte;
              crc_idx_q <= 1'b1;
            end else begin
              tdata_q  <= pack_q;
              tkeep_q  <= keep_last;
              tlast_q  <= 1'b1;
              tuser_q  <= crc_bad;
              tvalid_q <= 1'b1;
              if (crc_bad && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
              end
              pack_q    <= '0;
              crc_idx_q <= 1'b0;
              state_q   <= ST_HUNT;
            end
          end
`endif

          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  assign bus.s_axis_demod_tready = in_ready;
  assign bus.m_axis_c2h_tdata    = tdata_q;
  assign bus.m_axis_c2h_tkeep    = tkeep_q;
  assign bus.m_axis_c2h_tvalid   = tvalid_q;
  assign bus.m_axis_c2h_tlast    = tlast_q;
  assign locked                  = (state_q != ST_HUNT);
  assign frame_cnt               = frame_cnt_q;
  assign err_cnt                 = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bbp_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bbp_rx_deframer
// Purpose  : Self-checking bench for bbp_rx_deframer. Frames are built from
//            payload byte lists; the expected C2H beats are derived by
//            slicing each payload into 8-byte chunks. A monitor compares
//            every output handshake against that list and checks the
//            backpressure and hold rules each cycle.
// Options  : honours `define BBP_RX_CRC_EN (appends CRC bytes to frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bbp_rx_deframer;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        clk_250m = 1'b0;
  logic        reset    = 1'b1;
  logic        locked;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  always #5 clk_250m = ~clk_250m;

  bbp_rx_deframer_if #(.DATA_W(64)) bus ();

  bbp_rx_deframer dut (
    .clk_250m  (clk_250m),
    .reset     (reset),
    .bus       (bus),
    .locked    (locked),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  int    n_pass     = 0;
  int    n_checks   = 0;
  beat_t exp_q[$];
  int    exp_frames = 0;
  int    exp_err    = 0;
  int    hs_cnt     = 0;
  int    stall_cnt  = 0;
  bit    rand_rdy   = 1'b0;
  bit    saw_bp     = 1'b0;
  beat_t last_beat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Bit-serial CRC-16-CCITT, MSB first, init 0xFFFF.
  function automatic logic [15:0] crc_ccitt(input logic [7:0] b[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[i][k];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  // One clock of stimulus: drive at the falling edge, report acceptance.
  task automatic tick(input bit v, input logic [7:0] d, output bit acc);
    @(negedge clk_250m);
    if (stall_cnt > 0) begin
      bus.m_axis_c2h_tready = 1'b0;
      stall_cnt--;
    end else begin
      bus.m_axis_c2h_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.s_axis_demod_tvalid = v;
    bus.s_axis_demod_tdata  = d;
    #1;
    acc = v && bus.s_axis_demod_tready;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, acc);
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    bit acc;
    int n;
    foreach (q[i]) begin
      n = 0;
      do begin
        tick(1'b1, q[i], acc);
        n++;
      end while (!acc && n < 200);
      if (!acc) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input bit bad_crc);
    logic [7:0]  q[$];
    logic [7:0]  crc_in[$];
    logic [15:0] len;
    logic [15:0] crc;
    beat_t       b;
    len = 16'(pl.size());
    q = '{8'hEB, 8'h90, 8'h14, 8'h6F};
    q.push_back(len[15:8]);
    q.push_back(len[7:0]);
    crc_in.push_back(len[15:8]);
    crc_in.push_back(len[7:0]);
    foreach (pl[i]) begin
      q.push_back(pl[i]);
      crc_in.push_back(pl[i]);
    end
    crc = crc_ccitt(crc_in);
`ifdef BBP_RX_CRC_EN
    if (bad_crc) crc = crc ^ 16'h0001;
    q.push_back(crc[15:8]);
    q.push_back(crc[7:0]);
    if (bad_crc) exp_err++;
`else
    crc = crc ^ 16'(bad_crc);
`endif
    for (int w = 0; w * 8 < int'(len); w++) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        if (w * 8 + j < int'(len)) begin
          b.data[j*8 +: 8] = pl[w*8 + j];
          b.keep[j]        = 1'b1;
        end
      end
      b.last = (w * 8 + 8 >= int'(len));
`ifdef BBP_RX_CRC_EN
      b.user = b.last && bad_crc;
`endif
      exp_q.push_back(b);
    end
    send_bytes(q);
  endtask

  // Monitor: sample away from the rising edge, after the stimulus settles.
  logic [63:0] prev_data;
  logic [9:0]  prev_side;
  logic        prev_stall = 1'b0;

  always begin : mon
    logic [9:0] side;
    beat_t      e;
    @(negedge clk_250m);
    #2;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      side = {bus.m_axis_c2h_tkeep, bus.m_axis_c2h_tlast, bus.m_axis_c2h_tuser};
      chk("s_tready", 64'(bus.s_axis_demod_tready),
          64'(!(bus.m_axis_c2h_tvalid && !bus.m_axis_c2h_tready)));
      chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.m_axis_c2h_tvalid), 64'd1);
        chk("hold_data", bus.m_axis_c2h_tdata, prev_data);
        chk("hold_side", 64'(side), 64'(prev_side));
      end
      if (bus.m_axis_c2h_tvalid && !bus.m_axis_c2h_tready && !bus.s_axis_demod_tready)
        saw_bp = 1'b1;
      if (bus.m_axis_c2h_tvalid && bus.m_axis_c2h_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", bus.m_axis_c2h_tdata, e.data);
          chk("beat_keep_last_user", 64'(side), 64'({e.keep, e.last, e.user}));
          if (e.last) exp_frames++;
        end
        hs_cnt++;
        last_beat = {bus.m_axis_c2h_tdata, side};
      end
      prev_stall = bus.m_axis_c2h_tvalid && !bus.m_axis_c2h_tready;
      prev_data  = bus.m_axis_c2h_tdata;
      prev_side  = side;
    end
  end

  initial begin : main
    logic [7:0] pl[$];
    logic [7:0] raw[$];
    bit         acc;
    int         hs0;

    bus.s_axis_demod_tvalid = 1'b0;
    bus.s_axis_demod_tdata  = 8'h00;
    bus.m_axis_c2h_tready   = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk_250m);
    #2;
    chk("rst_tvalid", 64'(bus.m_axis_c2h_tvalid), 64'd0);
    chk("rst_tdata",  bus.m_axis_c2h_tdata, 64'd0);
    chk("rst_tkeep",  64'(bus.m_axis_c2h_tkeep), 64'd0);
    chk("rst_tlast",  64'(bus.m_axis_c2h_tlast), 64'd0);
    chk("rst_tuser",  64'(bus.m_axis_c2h_tuser), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_frames", 64'(frame_cnt), 64'd0);
    chk("rst_errs",   64'(err_cnt), 64'd0);
    chk("rst_s_tready", 64'(bus.s_axis_demod_tready), 64'd1);
    @(negedge clk_250m);
    reset = 1'b0;

    // Full 8-byte frame: one beat, output rises the cycle after the last byte.
    pl.delete();
    for (int i = 1; i <= 8; i++) pl.push_back(8'(i));
    send_frame(pl, 1'b0);
    tick(1'b0, 8'h00, acc);
    chk("latency_tvalid", 64'(bus.m_axis_c2h_tvalid), 64'd1);
    idle(5);
    chk("f8_data", last_beat.data, 64'h0807060504030201);
    chk("f8_keep", 64'(last_beat.keep), 64'hFF);
    chk("f8_last", 64'(last_beat.last), 64'd1);
    chk("f8_frames", 64'(frame_cnt), 64'd1);
    chk("f8_unlocked", 64'(locked), 64'd0);

    // 11-byte frame: full word then a 3-byte tail.
    pl.delete();
    for (int i = 1; i <= 11; i++) pl.push_back(8'(i));
    send_frame(pl, 1'b0);
    idle(5);
    chk("f11_tail", 64'(last_beat.data[23:0]), 64'h0B0A09);
    chk("f11_keep", 64'(last_beat.keep), 64'h07);
    chk("f11_last", 64'(last_beat.last), 64'd1);

    // Illegal lengths 0 and 1501.
    hs0 = hs_cnt;
    send_bytes('{8'hEB, 8'h90, 8'h14, 8'h6F});
    tick(1'b0, 8'h00, acc);
    chk("sync_locked", 64'(locked), 64'd1);
    send_bytes('{8'h00, 8'h00, 8'hEB, 8'h90, 8'h14, 8'h6F, 8'h05, 8'hDD});
    exp_err += 2;
    idle(5);
    chk("badlen_errs", 64'(err_cnt), 64'(exp_err));
    chk("badlen_errs_lit", 64'(err_cnt), 64'd2);
    chk("badlen_unlocked", 64'(locked), 64'd0);
    chk("badlen_no_beats", 64'(hs_cnt - hs0), 64'd0);

    // 16-byte frame under a 20-cycle sink stall.
    saw_bp = 1'b0;
    stall_cnt = 20;
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'(8'h10 + i));
    send_frame(pl, 1'b0);
    idle(30);
    chk("stall_backpressure_seen", 64'(saw_bp), 64'd1);
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Sync pattern inside the payload, then a short frame.
    pl = '{8'hAA, 8'hEB, 8'h90, 8'h14, 8'h6F, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(pl, 1'b0);
    pl = '{8'hC1, 8'hC2, 8'hC3};
    send_frame(pl, 1'b0);

    // 9 bytes: tail word loads in the same cycle the first word departs.
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h40 + i));
    send_frame(pl, 1'b0);

    // Longer frame with a randomly ready sink.
    rand_rdy = 1'b1;
    pl.delete();
    for (int i = 0; i < 40; i++) pl.push_back(8'($urandom));
    send_frame(pl, 1'b0);
    idle(40);
    rand_rdy = 1'b0;
    idle(5);
    chk("mixed_drained", 64'(exp_q.size()), 64'd0);

`ifdef BBP_RX_CRC_EN
    pl = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    send_frame(pl, 1'b1);
    idle(5);
    chk("crc_bad_user", 64'(last_beat.user), 64'd1);
    chk("crc_bad_errs", 64'(err_cnt), 64'(exp_err));
    chk("crc_bad_errs_lit", 64'(err_cnt), 64'd3);
    send_frame(pl, 1'b0);
    idle(5);
    chk("crc_good_user", 64'(last_beat.user), 64'd0);
    chk("crc_good_errs", 64'(err_cnt), 64'(exp_err));
`endif

    // Reset after 5 of 8 payload bytes, then a clean frame.
    raw = '{8'hEB, 8'h90, 8'h14, 8'h6F, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_bytes(raw);
    tick(1'b0, 8'h00, acc);
    reset = 1'b1;
    exp_frames = 0;
    exp_err    = 0;
    idle(2);
    chk("midrst_tvalid", 64'(bus.m_axis_c2h_tvalid), 64'd0);
    chk("midrst_locked", 64'(locked), 64'd0);
    reset = 1'b0;
    hs0 = hs_cnt;
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'(8'h21 + i));
    send_frame(pl, 1'b0);
    idle(5);
    chk("midrst_beats", 64'(hs_cnt - hs0), 64'd1);
    chk("midrst_data", last_beat.data, 64'h2827262524232221);
    chk("midrst_frames", 64'(frame_cnt), 64'd1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
